// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer with an Avalon-MM slave register interface.
// Each channel has a prescaler, a down-counter with a reload PERIOD, a
// timeout flag with an interrupt enable, and a counter SNAPSHOT register.
// Word address = {channel, register}; channels beyond NUM_CH read as zero.
module nios_multi_timer #(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  parameter int          ADDR_W         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  typedef enum logic [1:0] {
    REG_STATUS   = 2'd0,
    REG_CONTROL  = 2'd1,
    REG_PERIOD   = 2'd2,
    REG_SNAPSHOT = 2'd3
  } reg_e;

  localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-channel state
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [7:0]        r_presc  [NUM_CH];
  logic [7:0]        r_pcnt   [NUM_CH];
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_ito;
  logic [NUM_CH-1:0] r_cont;
  logic [31:0]       r_readdata;

  // Bus decode
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_ch_idx;
  reg_e              w_reg;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_timeout;
  logic [31:0]       w_rdata;

  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & ~read_n;
  assign w_ch_idx = address >> 2;
  assign w_reg    = reg_e'(address[1:0]);

  // Channel select, prescaler tick and timeout event per channel
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_sel     = '0;
    w_tick    = '0;
    w_timeout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel indices match no i, so they select nothing.
      w_sel[i]     = (w_ch_idx == ADDR_W'(i));
      w_tick[i]    = r_run[i] && (r_pcnt[i] == r_presc[i]);
      w_timeout[i] = w_tick[i] && (r_cnt[i] == '0);
    end
  end

  // Channel state: counting first, bus writes afterwards so writes take priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these arrays are a handful of flops, not a RAM, so resetting them all is intended and cheap.
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= DEF_P;
        r_period[i] <= DEF_P;
        r_snap[i]   <= '0;
        r_presc[i]  <= '0;
        r_pcnt[i]   <= '0;
      end
      r_to   <= '0;
      r_run  <= '0;
      r_ito  <= '0;
      r_cont <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: non-blocking assignments; when one register is assigned twice in this block the later (bus write) one wins.
        if (w_tick[i]) begin
          r_pcnt[i] <= '0;
          if (w_timeout[i]) begin
            r_cnt[i] <= r_period[i];
            r_to[i]  <= 1'b1;
            if (!r_cont[i]) r_run[i] <= 1'b0;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_ONE;
          end
        end else if (r_run[i]) begin
          r_pcnt[i] <= r_pcnt[i] + 8'd1;
        end

        if (w_wr && w_sel[i]) begin
          case (w_reg)
            REG_STATUS: begin
              // A timeout landing in the same cycle as the clear keeps TO set.
              if (writedata[0] && !w_timeout[i]) r_to[i] <= 1'b0;
            end
            REG_CONTROL: begin
              r_ito[i]   <= writedata[0];
              r_cont[i]  <= writedata[1];
              r_presc[i] <= writedata[15:8];
              if (writedata[3]) begin
                r_run[i] <= 1'b0;
              end else if (writedata[2]) begin
                r_run[i]  <= 1'b1;
                r_pcnt[i] <= '0;
              end
            end
            REG_PERIOD: begin
              r_period[i] <= writedata[CNT_W-1:0];
              r_cnt[i]    <= writedata[CNT_W-1:0];
              r_pcnt[i]   <= '0;
            end
            REG_SNAPSHOT: begin
              r_snap[i] <= r_cnt[i];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux for the addressed channel/register
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel[i]) begin
        case (w_reg)
          REG_STATUS:   w_rdata = {30'h0, r_run[i], r_to[i]};
          REG_CONTROL:  w_rdata = {16'h0, r_presc[i], 6'h0, r_cont[i], r_ito[i]};
          REG_PERIOD:   w_rdata = 32'(r_period[i]);
          REG_SNAPSHOT: w_rdata = 32'(r_snap[i]);
          default:      w_rdata = '0;
        endcase
      end
    end
  end

  // Registered read data, updated only on a read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq_vec  = r_to & r_ito;
  assign irq      = |irq_vec;

endmodule

// File: doc/nios_multi_timer.md
NIOS_MULTI_TIMER -- requirements
Module: nios_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning counter and period width in bits (8..32).
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 49999, meaning reset value of every PERIOD register and counter.
REQ-004 SHALL have parameter ADDR_W = clog2(NUM_CH)+2 (derived), meaning word address width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port address, input, ADDR_W, meaning word address: channel = address[ADDR_W-1:2], register = address[1:0].
REQ-008 SHALL have ports chipselect, write_n, read_n (inputs, 1 each), meaning Avalon-MM slave strobes, write/read active when chipselect=1 and the respective strobe is 0.
REQ-009 SHALL have port writedata, input, 32, meaning write data.
REQ-010 SHALL have port readdata, output, 32, meaning registered read data.
REQ-011 SHALL have port irq_vec, output, NUM_CH, meaning per-channel interrupt; irq, output, 1, meaning OR of irq_vec.

Function
REQ-012 Register map per channel: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAPSHOT; channel index >= NUM_CH SHALL read 0 and ignore writes.
REQ-013 STATUS SHALL be bit0 TO (write-1-to-clear), bit1 RUN (read-only), others read 0.
REQ-014 CONTROL SHALL be bit0 ITO, bit1 CONT, bit2 START (self-clearing, reads 0), bit3 STOP (self-clearing, reads 0), bits15:8 PRESC; others read 0.
REQ-015 Reads SHALL have fixed latency 1: readdata registered from address every cycle chipselect=1 and read_n=0, else holds.
REQ-016 Per channel, prescaler SHALL assert tick once every PRESC+1 clocks while RUN=1; PRESC=0 gives tick every clock.
REQ-017 On tick with counter != 0, counter SHALL decrement by 1.
REQ-018 On tick with counter == 0: TO SHALL set, counter SHALL reload PERIOD[CNT_W-1:0], RUN SHALL clear if CONT=0 else remain 1.
REQ-019 Timeout period SHALL therefore be (PERIOD+1)*(PRESC+1) clocks; PERIOD=0 with CONT=1 gives timeout every PRESC+1 clocks.
REQ-020 START write SHALL set RUN and zero the prescaler next cycle without reloading counter; STOP write SHALL clear RUN, counter frozen.
REQ-021 START and STOP written together SHALL result in RUN=0 (STOP wins).
REQ-022 PERIOD write SHALL update PERIOD, reload counter with writedata[CNT_W-1:0], and zero the prescaler on the next cycle; RUN SHALL be unchanged.
REQ-023 SNAPSHOT write (any data) SHALL capture current counter into SNAPSHOT; read returns it zero-extended to 32 bits.
REQ-024 Writedata bits above CNT_W in PERIOD SHALL be ignored and read back 0.
REQ-025 TO set event and TO W1C clear in the same cycle SHALL leave TO=1 (set wins).
REQ-026 irq_vec[i] SHALL equal TO[i] AND ITO[i], combinational from registered state; irq = OR of irq_vec.
REQ-027 Channels SHALL be fully independent; a write to one channel SHALL not affect another.

Reset
REQ-028 While reset=1: counter and PERIOD = DEFAULT_PERIOD, SNAPSHOT=0, CONTROL=0, TO=0, RUN=0, prescaler=0, readdata=0, irq_vec=0, irq=0.
REQ-029 Reset asserted mid-count SHALL abort immediately; after release, channel SHALL stay idle until START.

Verification
REQ-030 Reset, read ch0 PERIOD -> readdata=49999 one cycle after read; STATUS=0; irq=0.
REQ-031 ch0 PERIOD=4, CONTROL=0x0007 (ITO,CONT,START) -> TO every 5 clocks, irq_vec[0]=1 after first timeout, RUN stays 1.
REQ-032 ch1 PERIOD=2, CONTROL=0x0304 (PRESC=3, one-shot, START) -> TO after 12 clocks, RUN=0, counter=2.
REQ-033 ch0 running CONT, W1C STATUS=0x1 on the exact timeout cycle -> TO remains 1; W1C next cycle -> TO=0, irq=0.
REQ-034 ch0 PERIOD=100 running, SNAPSHOT write after 10 clocks -> SNAPSHOT read = 90; PERIOD write 7 mid-count -> counter=7, RUN=1.
REQ-035 CONTROL=0x000C (START+STOP) -> RUN=0; write to channel NUM_CH -> no state change, read returns 0.
